generate_lights: RTL and testbench

//  - Pipe/obstacle generator for the 16x16 LED-matrix Flappy-Bird game.
//  - Keeps a scrolling 16x16 obstacle field on the green plane: vertical pipes,

---
 rtl/game_pkg.sv | 22 ++
 rtl/lfsr16.sv | 26 ++
 rtl/generate_lights.sv | 104 ++++++++++
 tb/tb_generate_lights.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the LED-matrix game.
// Provides the 16x16 plane type, the grid size and a pipe-column builder.
package game_pkg;

   localparam int unsigned GRID_N = 16;

   // [row][col]: row 0 is the top row, col 0 is the right edge
   typedef logic [GRID_N-1:0][GRID_N-1:0] pixel_plane_t;
   typedef logic [GRID_N-1:0]             pixel_col_t;

   // One pipe column: lit everywhere except rows gap_top .. gap_top+gap_h-1
   function automatic pixel_col_t pipe_column(input logic [7:0] gap_top,
                                              input logic [7:0] gap_h);
      pixel_col_t col;
      col = '0;
      for (int r = 0; r < GRID_N; r++) begin
         col[r] = (8'(r) < gap_top) || (8'(r) >= (gap_top + gap_h));
      end
      return col;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left when enabled.
// Ports: clk, reset (async active-low, loads SEED), enable (advance one step),
//        state (current 16-bit register value).
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [15:0] state
);

   logic feedback;

   assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

   // A nonzero seed can never reach the all-zero lock-up state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= SEED;
      end else if (enable) begin
         state <= {state[14:0], feedback};
      end
   end

endmodule

// File: rtl/generate_lights.sv
// Pipe/obstacle generator for the 16x16 Flappy-Bird LED matrix.
// Scrolls a field of vertical pipes (each with a pseudo-random gap) from the
// right edge (col 0) leftwards and flags pipes in the bird column.
// Ports: clk, reset (async active-low), GrnPixels (green plane [row][col]),
//        RedPixels (always zero), out (1 while column BIRD_COL holds any pixel).
module generate_lights
   import game_pkg::*;
#(
   parameter int unsigned SCROLL_DIV   = 1,
   parameter int unsigned PIPE_SPACING = 6,
   parameter int unsigned GAP_H        = 4,
   parameter int unsigned BIRD_COL     = 13,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic         clk,
   input  logic         reset,
   output pixel_plane_t GrnPixels,
   output pixel_plane_t RedPixels,
   output logic         out
);

   localparam int unsigned DIV_W   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int unsigned SPAWN_W = $clog2(PIPE_SPACING);
   localparam logic [7:0]  GAP_MOD = 8'(GRID_N + 1 - GAP_H);
   localparam logic [7:0]  GAP_LEN = 8'(GAP_H);

   logic [DIV_W-1:0]   div_cnt;
   logic               tick;
   logic [SPAWN_W-1:0] spawn_cnt;
   logic [15:0]        lfsr;
   logic               lfsr_unused;
   logic [7:0]         gap_top;
   pixel_col_t         newcol;

   assign tick = (div_cnt == DIV_W'(SCROLL_DIV - 1));

   // Scroll-rate divider
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Gap source; advances on every scroll step, pipe or not
   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .enable (tick),
      .state  (lfsr)
   );

   // Only the low byte picks the gap
   assign lfsr_unused = ^lfsr[15:8];

   // Column entering at the right edge: a pipe when the spacing counter is 0
   always_comb begin
      gap_top = lfsr[7:0] % GAP_MOD;
      newcol  = '0;
      if (spawn_cnt == '0) begin
         newcol = pipe_column(gap_top, GAP_LEN);
      end
   end

   // Pipe spacing counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spawn_cnt <= '0;
      end else if (tick) begin
         if (spawn_cnt == '0) begin
            spawn_cnt <= SPAWN_W'(PIPE_SPACING - 1);
         end else begin
            spawn_cnt <= spawn_cnt - SPAWN_W'(1);
         end
      end
   end

   // Shift array: each row moves one column left, col 15 falls off
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         GrnPixels <= '0;
      end else if (tick) begin
         for (int r = 0; r < GRID_N; r++) begin
            GrnPixels[r] <= {GrnPixels[r][GRID_N-2:0], newcol[r]};
         end
      end
   end

   assign RedPixels = '0;

   // Bird-column occupancy, straight from the registered plane
   always_comb begin
      out = 1'b0;
      for (int r = 0; r < GRID_N; r++) begin
         out = out | GrnPixels[r][BIRD_COL];
      end
   end

endmodule

// File: tb/tb_generate_lights.sv
// Self-checking bench for generate_lights: a default build and a SCROLL_DIV=4
// build share one reset. A pipe-list reference model (birth tick + gap row per
// pipe) predicts both planes and the bird flag every cycle; random run lengths
// and randomly timed asynchronous resets exercise restart determinism.
module tb_generate_lights;
   import game_pkg::*;

   localparam int SPACING = 6;
   localparam int GAPH    = 4;
   localparam int BIRD    = 13;

   logic         clk = 1'b0;
   logic         reset;
   pixel_plane_t grn1, red1, grn4, red4;
   logic         out1, out4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   generate_lights u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .GrnPixels (grn1),
      .RedPixels (red1),
      .out       (out1)
   );

   generate_lights #(
      .SCROLL_DIV (4)
   ) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .GrnPixels (grn4),
      .RedPixels (red4),
      .out       (out4)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: per build, tick count, LFSR value and the live pipes
   int cyc;
   int ticks  [2];
   int lfsr_m [2];
   int np     [2];
   int born   [2][8];
   int gp     [2][8];

   task automatic model_reset();
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
         ticks[d]  = 0;
         lfsr_m[d] = 16'hACE1;
         np[d]     = 0;
      end
   endtask

   task automatic model_edge();
      int div;
      for (int d = 0; d < 2; d++) begin
         div = (d == 0) ? 1 : 4;
         if (cyc % div == div - 1) begin
            ticks[d]++;
            if ((ticks[d] - 1) % SPACING == 0) begin
               if (np[d] == 8) begin
                  for (int i = 0; i < 7; i++) begin
                     born[d][i] = born[d][i+1];
                     gp[d][i]   = gp[d][i+1];
                  end
                  np[d] = 7;
               end
               born[d][np[d]] = ticks[d];
               gp[d][np[d]]   = (lfsr_m[d] & 255) % (17 - GAPH);
               np[d]++;
            end
            lfsr_m[d] = ((lfsr_m[d] << 1) |
                         (((lfsr_m[d] >> 15) ^ (lfsr_m[d] >> 13) ^
                           (lfsr_m[d] >> 12) ^ (lfsr_m[d] >> 10)) & 1)) & 16'hFFFF;
         end
      end
      cyc++;
   endtask

   function automatic pixel_plane_t model_plane(input int d);
      pixel_plane_t p;
      int pos;
      p = '0;
      for (int i = 0; i < np[d]; i++) begin
         pos = ticks[d] - born[d][i];
         if (pos >= 0 && pos < 16) begin
            for (int r = 0; r < 16; r++) begin
               if (r < gp[d][i] || r >= gp[d][i] + GAPH) p[r][pos] = 1'b1;
            end
         end
      end
      return p;
   endfunction

   // A gap never spans the full height, so any pipe at BIRD lights that column
   function automatic logic model_out(input int d);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < np[d]; i++) begin
         if (ticks[d] - born[d][i] == BIRD) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic [15:0] col_of(input pixel_plane_t p, input int c);
      logic [15:0] v;
      for (int r = 0; r < 16; r++) v[r] = p[r][c];
      return v;
   endfunction

   task automatic check_all();
      check("grn_div1", grn1, model_plane(0));
      check("red_div1", red1, '0);
      check("out_div1", 256'(out1), 256'(model_out(0)));
      check("grn_div4", grn4, model_plane(1));
      check("red_div4", red4, '0);
      check("out_div4", 256'(out4), 256'(model_out(1)));
   endtask

   task automatic run_cycle();
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      check_all();
   endtask

   // Runs n cycles after a release, adding fixed-pattern checks on known cycles
   task automatic run_from_release(input int n);
      pixel_plane_t t;
      logic [15:0]  mid;
      for (int k = 1; k <= n; k++) begin
         run_cycle();
         if (k == 1) begin
            check("first_pipe_col0", 256'(col_of(grn1, 0)), 256'(16'hFF0F));
            t = grn1;
            for (int r = 0; r < 16; r++) t[r][0] = 1'b0;
            check("first_cols1_15_empty", t, '0);
         end
         if (k == 3) check("div4_hold_empty", grn4, '0);
         if (k == 4) check("div4_first_col0", 256'(col_of(grn4, 0)), 256'(16'hFF0F));
         if (k == 7) begin
            check("first_pipe_col6", 256'(col_of(grn1, 6)), 256'(16'hFF0F));
            mid = col_of(grn1, 1) | col_of(grn1, 2) | col_of(grn1, 3) |
                  col_of(grn1, 4) | col_of(grn1, 5);
            check("spacing_cols1_5_empty", 256'(mid), '0);
         end
         if (k == 13) check("out_pipe_at_12", 256'(out1), 256'(1'b0));
         if (k == 14) check("out_pipe_at_13", 256'(out1), 256'(1'b1));
         if (k == 15) check("out_pipe_at_14", 256'(out1), 256'(1'b0));
      end
   endtask

   // Asynchronous reset between edges; checks the clear before the next edge
   task automatic async_reset(input int offset);
      #(offset);
      reset = 1'b0;
      model_reset();
      #1;
      check("async_clear_grn1", grn1, '0);
      check("async_clear_out1", 256'(out1), '0);
      check("async_clear_grn4", grn4, '0);
      check_all();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_grn", grn1, '0);
      check("reset_red", red1, '0);
      check("reset_out", 256'(out1), '0);
      check_all();

      reset = 1'b1;
      run_from_release(17);

      async_reset(2);
      repeat (2) run_cycle();
      reset = 1'b1;
      run_from_release(20);

      for (int it = 0; it < 10; it++) begin
         async_reset(int'($urandom_range(1, 3)));
         repeat (int'($urandom_range(0, 2))) run_cycle();
         reset = 1'b1;
         run_from_release(int'($urandom_range(1, 60)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
